// File: rtl/en_register_32_if.sv
// rtl/en_register_32_if.sv - data/enable/output bundle for the enabled register
`timescale 1ps/1ps

interface en_register_32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic             en;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        output en,
        input  out
    );

    modport slave (
        input  in,
        input  en,
        output out
    );
endinterface

// File: rtl/en_register_32.sv
// rtl/en_register_32.sv - clock-enabled data register with asynchronous reset
`timescale 1ps/1ps

module en_register_32 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    en_register_32_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("en_register_32: WIDTH must be in 1..64");
    end

    // out comes straight from the flops; en only selects recirculation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out <= RESET_VALUE;
        end else if (bus.en) begin
            bus.out <= bus.in;
        end
    end

`ifndef SYNTHESIS
    a_reset_value: assert property (@(posedge clk) rst |-> (bus.out == RESET_VALUE));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        !bus.en |=> $stable(bus.out));

    a_load: assert property (@(posedge clk) disable iff (rst)
        bus.en |=> (bus.out == $past(bus.in)));
`endif

endmodule

// File: tb/tb_en_register_32.sv
// tb/tb_en_register_32.sv - scoreboard bench for en_register_32 (32-bit and 8-bit instances)
`timescale 1ps/1ps

module tb_en_register_32;

    logic clk = 1'b0;
    logic rst;

    en_register_32_if #(.WIDTH(32)) wbus ();
    en_register_32_if #(.WIDTH(8))  nbus ();

    en_register_32 #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    en_register_32 #(.WIDTH(8), .RESET_VALUE(8'h80)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (nbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        narrow;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   push_cnt = 0;
    int   pop_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_out(input string name, input logic narrow, input logic [31:0] value);
        exp_t e;
        e.name   = name;
        e.narrow = narrow;
        e.value  = value;
        exp_q.push_back(e);
        push_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            wait (push_cnt != pop_cnt);
            e = exp_q.pop_front();
            pop_cnt++;
            act = e.narrow ? {24'h0, nbus.out} : wbus.out;
            checks++;
            if (act !== e.value) begin
                failures++;
                $display("FAIL %s: out=%h expected=%h", e.name, act, e.value);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] b2b [5];
        b2b = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000};

        rst      = 1'b1;
        wbus.in  = 32'hFFFF_FFFF;
        wbus.en  = 1'b1;
        nbus.in  = 8'h7F;
        nbus.en  = 1'b1;

        #1;
        expect_out("reset_initial", 1'b0, 32'h0000_0000);
        expect_out("reset_initial_n8", 1'b1, 32'h0000_0080);
        tick();
        expect_out("reset_cycle1", 1'b0, 32'h0000_0000);
        tick();
        expect_out("reset_cycle2", 1'b0, 32'h0000_0000);
        expect_out("reset_cycle2_n8", 1'b1, 32'h0000_0080);

        @(negedge clk);
        rst     = 1'b0;
        wbus.in = 32'hDEAD_BEEF;
        wbus.en = 1'b1;
        nbus.en = 1'b0;
        tick();
        expect_out("load_deadbeef", 1'b0, 32'hDEAD_BEEF);
        expect_out("hold_n8_after_release", 1'b1, 32'h0000_0080);

        @(negedge clk);
        wbus.en = 1'b0;
        wbus.in = 32'h1234_5678;
        nbus.en = 1'b1;
        nbus.in = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("hold_edge%0d", i), 1'b0, 32'hDEAD_BEEF);
        end
        expect_out("load_n8_7f", 1'b1, 32'h0000_007F);

        foreach (b2b[i]) begin
            @(negedge clk);
            wbus.en = 1'b1;
            wbus.in = b2b[i];
            nbus.en = 1'b0;
            tick();
            expect_out($sformatf("back_to_back%0d", i), 1'b0, b2b[i]);
        end

        @(negedge clk);
        wbus.in = 32'hA5A5_A5A5;
        tick();
        expect_out("load_a5", 1'b0, 32'hA5A5_A5A5);
        #1 rst = 1'b1;
        #1;
        expect_out("async_clear", 1'b0, 32'h0000_0000);
        expect_out("async_clear_n8", 1'b1, 32'h0000_0080);

        @(negedge clk);
        wbus.in = 32'hCAFE_F00D;
        wbus.en = 1'b1;
        nbus.in = 8'h11;
        nbus.en = 1'b1;
        tick();
        expect_out("priority_rst_over_en", 1'b0, 32'h0000_0000);
        expect_out("priority_rst_over_en_n8", 1'b1, 32'h0000_0080);
        #1 rst = 1'b0;
        #1;
        expect_out("post_release_no_edge", 1'b0, 32'h0000_0000);

        @(negedge clk);
        wbus.in = 32'h5A5A_5A5A;
        nbus.en = 1'b0;
        tick();
        expect_out("reload_5a", 1'b0, 32'h5A5A_5A5A);
        expect_out("hold_n8_post_release", 1'b1, 32'h0000_0080);

        @(negedge clk);
        wbus.en = 1'b0;
        wbus.in = 32'h0000_0000;
        #2;
        wbus.en = 1'b1;
        wbus.in = 32'hFFFF_FFFF;
        #1;
        wbus.en = 1'b0;
        tick();
        expect_out("glitch_en_ignored", 1'b0, 32'h5A5A_5A5A);

        #2;
        checks++;
        if (pop_cnt != push_cnt) begin
            failures++;
            $display("FAIL scoreboard_drain: popped=%0d pushed=%0d", pop_cnt, push_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
